// File: rtl/dqs_write_strobe_gen.sv
// DDR write burst strobe/data phase generator (x2 gearing); pins are registered, 1-cycle latency.
// Backpressure: cmd_ready only in IDLE; wr_ready only in DATA, and a missing beat is masked rather than stalled.
module dqs_write_strobe_gen #(
  parameter int DQ_W     = 8,
  parameter int LEN_W    = 4,
  parameter int PREAMBLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_beats,
  input  logic [3:0]            wl_cfg,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2*DQ_W-1:0]     wr_data,
  input  logic [DQ_W/4-1:0]     wr_mask,
  output logic [DQ_W-1:0]       dq_p0,
  output logic [DQ_W-1:0]       dq_p1,
  output logic [DQ_W/8-1:0]     dm_p0,
  output logic [DQ_W/8-1:0]     dm_p1,
  output logic                  dqs_p0,
  output logic                  dqs_p1,
  output logic                  dqs_oe,
  output logic                  dq_oe,
  output logic                  busy,
  output logic                  err_underrun
);

  localparam int DM_W  = DQ_W / 8;
  localparam int PRE_W = (PREAMBLE > 1) ? $clog2(PREAMBLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_DATA,
    S_POST
  } state_t;

  state_t             state;
  logic [3:0]         wl_cnt;
  logic [PRE_W-1:0]   pre_cnt;
  logic [LEN_W-1:0]   beat_cnt;
  logic               accept;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign cmd_ready = rst_n && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_ready  = (state == S_DATA);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wl_cnt       <= '0;
      pre_cnt      <= '0;
      beat_cnt     <= '0;
      dq_p0        <= '0;
      dq_p1        <= '0;
      dm_p0        <= '0;
      dm_p1        <= '0;
      dqs_p0       <= 1'b0;
      dqs_p1       <= 1'b0;
      dqs_oe       <= 1'b0;
      dq_oe        <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      // Pin registers capture the decode of the state being left this edge.
      dq_p0        <= '0;
      dq_p1        <= '0;
      dm_p0        <= '0;
      dm_p1        <= '0;
      dqs_p0       <= 1'b0;
      dqs_p1       <= 1'b0;
      dqs_oe       <= 1'b0;
      dq_oe        <= 1'b0;
      err_underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            beat_cnt <= cmd_beats;
            wl_cnt   <= wl_cfg - 4'd1;
            pre_cnt  <= PRE_W'(PREAMBLE - 1);
            state    <= (wl_cfg != 4'd0) ? S_WAIT : S_PRE;
          end
        end
        S_WAIT: begin
          if (wl_cnt == 4'd0) state <= S_PRE;
          else                wl_cnt <= wl_cnt - 4'd1;
        end
        S_PRE: begin
          dqs_oe <= 1'b1;
          if (pre_cnt == '0) state <= S_DATA;
          else               pre_cnt <= pre_cnt - 1'b1;
        end
        S_DATA: begin
          dqs_oe <= 1'b1;
          dq_oe  <= 1'b1;
          dqs_p0 <= 1'b1;
          if (wr_valid) begin
            dq_p0 <= wr_data[DQ_W-1:0];
            dq_p1 <= wr_data[2*DQ_W-1:DQ_W];
            dm_p0 <= wr_mask[DM_W-1:0];
            dm_p1 <= wr_mask[2*DM_W-1:DM_W];
          end else begin
            // Underrun: beat is masked out and the burst keeps its length.
            dm_p0        <= '1;
            dm_p1        <= '1;
            err_underrun <= 1'b1;
          end
          if (beat_cnt == '0) state <= S_POST;
          else                beat_cnt <= beat_cnt - 1'b1;
        end
        S_POST: begin
          dqs_oe <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dqs_write_strobe_gen.sv
// Directed bench for dqs_write_strobe_gen; expected pin vectors are queued per cycle and checked after the edge.
module tb_dqs_write_strobe_gen;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_beats;
  logic [3:0]  wl_cfg;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic [7:0]  dq_p0, dq_p1;
  logic [0:0]  dm_p0, dm_p1;
  logic        dqs_p0, dqs_p1, dqs_oe, dq_oe, busy, err_underrun;

  int tests  = 0;
  int failed = 0;

  typedef enum int {P_IDLE, P_WAIT, P_PRE, P_DATA, P_POST} phase_e;

  typedef struct packed {
    logic       dqs_oe;
    logic       dq_oe;
    logic       dqs_p0;
    logic       dqs_p1;
    logic [7:0] dq_p0;
    logic [7:0] dq_p1;
    logic       dm_p0;
    logic       dm_p1;
    logic       err;
  } pins_t;

  pins_t exp_q[$];

  dqs_write_strobe_gen #(.DQ_W(8), .LEN_W(4), .PREAMBLE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_beats    (cmd_beats),
    .wl_cfg       (wl_cfg),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .dq_p0        (dq_p0),
    .dq_p1        (dq_p1),
    .dm_p0        (dm_p0),
    .dm_p1        (dm_p1),
    .dqs_p0       (dqs_p0),
    .dqs_p1       (dqs_p1),
    .dqs_oe       (dqs_oe),
    .dq_oe        (dq_oe),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pins_t cur_pins();
    pins_t p;
    p.dqs_oe = dqs_oe;
    p.dq_oe  = dq_oe;
    p.dqs_p0 = dqs_p0;
    p.dqs_p1 = dqs_p1;
    p.dq_p0  = dq_p0;
    p.dq_p1  = dq_p1;
    p.dm_p0  = dm_p0[0];
    p.dm_p1  = dm_p1[0];
    p.err    = err_underrun;
    return p;
  endfunction

  // One clock cycle spent in phase ph; the pins for it are checked after the closing edge.
  task automatic cycle(input phase_e ph, input logic vld, input logic [15:0] d, input logic [1:0] m);
    pins_t e;
    pins_t g;
    wr_valid = vld;
    wr_data  = d;
    wr_mask  = m;
    #1;
    chk($sformatf("cmd_ready@%s", ph.name()), cmd_ready, ph == P_IDLE);
    chk($sformatf("busy@%s", ph.name()), busy, ph != P_IDLE);
    chk($sformatf("wr_ready@%s", ph.name()), wr_ready, ph == P_DATA);
    e = '0;
    e.dqs_oe = (ph == P_PRE) || (ph == P_DATA) || (ph == P_POST);
    if (ph == P_DATA) begin
      e.dq_oe  = 1'b1;
      e.dqs_p0 = 1'b1;
      if (vld) begin
        e.dq_p0 = d[7:0];
        e.dq_p1 = d[15:8];
        e.dm_p0 = m[0];
        e.dm_p1 = m[1];
      end else begin
        e.dm_p0 = 1'b1;
        e.dm_p1 = 1'b1;
        e.err   = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = cur_pins();
    e = exp_q.pop_front();
    chk($sformatf("pins_after_%s", ph.name()), 32'(g), 32'(e));
  endtask

  task automatic run_burst(input int wl, input int beats, input logic [15:0] vpat, input bit hold,
                           input bit fixed, input logic [15:0] fd, input logic [1:0] fm);
    logic [15:0] d;
    logic [1:0]  m;
    cmd_valid = 1'b1;
    cmd_beats = beats[3:0];
    wl_cfg    = wl[3:0];
    cycle(P_IDLE, 1'b1, 16'h0, 2'b00);
    cmd_valid = hold;
    cmd_beats = 4'($urandom);
    wl_cfg    = 4'($urandom);
    for (int i = 0; i < wl; i++) cycle(P_WAIT, 1'b1, 16'($urandom), 2'($urandom));
    cycle(P_PRE, 1'b1, 16'($urandom), 2'($urandom));
    for (int i = 0; i <= beats; i++) begin
      d = fixed ? fd : 16'($urandom);
      m = fixed ? fm : 2'($urandom);
      cycle(P_DATA, vpat[i], d, m);
    end
    cycle(P_POST, 1'b1, 16'($urandom), 2'($urandom));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_beats = 4'd3;
    wl_cfg    = 4'd0;
    wr_valid  = 1'b1;
    wr_data   = 16'hFFFF;
    wr_mask   = 2'b11;

    // Reset held with cmd_valid high: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_pins", 32'(cur_pins()), 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
    end
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // WL=2, 4 beats, continuous data.
    run_burst(2, 3, 16'hFFFF, 1'b0, 1'b0, 16'h0, 2'b00);
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);

    // WL=0, single beat with fixed data/mask.
    run_burst(0, 0, 16'hFFFF, 1'b0, 1'b1, 16'hA55A, 2'b10);
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);

    // Underrun on the second of four beats.
    run_burst(1, 3, 16'hFFFD, 1'b0, 1'b0, 16'h0, 2'b00);
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);

    // cmd_valid held high across back-to-back bursts.
    run_burst(1, 1, 16'hFFFF, 1'b1, 1'b0, 16'h0, 2'b00);
    run_burst(0, 0, 16'hFFFF, 1'b1, 1'b0, 16'h0, 2'b00);
    run_burst(3, 2, 16'hFFFF, 1'b1, 1'b0, 16'h0, 2'b00);
    cmd_valid = 1'b0;
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);

    // Reset asserted mid-DATA, then a clean 2-beat burst.
    cmd_valid = 1'b1;
    cmd_beats = 4'd3;
    wl_cfg    = 4'd0;
    cycle(P_IDLE, 1'b1, 16'h0, 2'b00);
    cmd_valid = 1'b0;
    cycle(P_PRE, 1'b1, 16'h1234, 2'b00);
    cycle(P_DATA, 1'b1, 16'hC3E7, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pins", 32'(cur_pins()), 32'h0);
    chk("async_rst_busy", busy, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_busy", busy, 1'b0);
    chk("rst_hold_pins", 32'(cur_pins()), 32'h0);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("rerelease_cmd_ready", cmd_ready, 1'b1);
    run_burst(0, 1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 2'b00);
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);

    // Maximum burst length: 16 beats, no wrap into another burst.
    run_burst(3, 15, 16'hFFFF, 1'b0, 1'b0, 16'h0, 2'b00);
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);
    cycle(P_IDLE, 1'b0, 16'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
